// File: rtl/fp_add_align_if.sv
// ============================================================================
//  Module      : fp_add_align_if
//  Description : Handshake and data bundle for the FP32 add/sub align stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_add_align_if;
    // upstream side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sub;
    // downstream side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic        eff_sub;
    logic        sign_out;
    logic [7:0]  exp_out;
    logic        special;
    logic [31:0] special_val;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, add_a, add_b, add_cin, eff_sub,
               sign_out, exp_out, special, special_val
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, add_a, add_b, add_cin, eff_sub,
               sign_out, exp_out, special, special_val
    );
endinterface

`default_nettype wire

// File: rtl/fp_add_align.sv
// ============================================================================
//  Module      : fp_add_align
//  Description : FP32 add/sub pre-adder: unpack, classify, order by magnitude,
//                align smaller mantissa with sticky; 2-stage valid/ready pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_align (
    input  logic             clk,
    input  logic             rst,
    fp_add_align_if.slave    bus
);

    localparam logic [31:0] C_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  C_EXP_MAX = 8'hFF;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_ready;
    logic w_s1_ready;
    logic w_s1_load;
    logic w_s2_load;

    assign w_s2_ready = ~r_s2_valid | bus.out_ready;
    assign w_s1_ready = ~r_s1_valid | w_s2_ready;
    assign w_s1_load  = bus.in_valid & w_s1_ready;
    assign w_s2_load  = r_s1_valid & w_s2_ready;

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, compare, swap
    // ------------------------------------------------------------------
    logic        w_sa;
    logic        w_sb;
    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic [22:0] w_fa;
    logic [22:0] w_fb;
    logic        w_ha;
    logic        w_hb;
    logic [7:0]  w_ea_adj;
    logic [7:0]  w_eb_adj;
    logic        w_nan_a;
    logic        w_nan_b;
    logic        w_inf_a;
    logic        w_inf_b;
    logic        w_swap;

    assign w_sa     = bus.op_a[31];
    assign w_sb     = bus.op_b[31] ^ bus.sub;
    assign w_ea     = bus.op_a[30:23];
    assign w_eb     = bus.op_b[30:23];
    assign w_fa     = bus.op_a[22:0];
    assign w_fb     = bus.op_b[22:0];
    assign w_ha     = (w_ea != 8'd0);
    assign w_hb     = (w_eb != 8'd0);
    assign w_ea_adj = w_ha ? w_ea : 8'd1;
    assign w_eb_adj = w_hb ? w_eb : 8'd1;
    assign w_nan_a  = (w_ea == C_EXP_MAX) && (w_fa != 23'd0);
    assign w_nan_b  = (w_eb == C_EXP_MAX) && (w_fb != 23'd0);
    assign w_inf_a  = (w_ea == C_EXP_MAX) && (w_fa == 23'd0);
    assign w_inf_b  = (w_eb == C_EXP_MAX) && (w_fb == 23'd0);
    // Raw {exp,frac} ordering matches true magnitude, denormals included.
    assign w_swap   = ({w_eb, w_fb} > {w_ea, w_fa});

    logic        w_s1_eff_sub;
    logic        w_s1_sign;
    logic [7:0]  w_s1_exp;
    logic [7:0]  w_s1_diff;
    logic [23:0] w_s1_big_man;
    logic [23:0] w_s1_small_man;
    logic        w_s1_special;
    logic [31:0] w_s1_special_val;

    always_comb begin
        w_s1_eff_sub     = w_sa ^ w_sb;
        w_s1_sign        = w_sa;
        w_s1_exp         = w_ea_adj;
        w_s1_diff        = w_ea_adj - w_eb_adj;
        w_s1_big_man     = {w_ha, w_fa};
        w_s1_small_man   = {w_hb, w_fb};
        w_s1_special     = 1'b0;
        w_s1_special_val = 32'd0;

        if (w_swap) begin
            w_s1_sign      = w_sb;
            w_s1_exp       = w_eb_adj;
            w_s1_diff      = w_eb_adj - w_ea_adj;
            w_s1_big_man   = {w_hb, w_fb};
            w_s1_small_man = {w_ha, w_fa};
        end

        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && w_s1_eff_sub)) begin
            w_s1_special     = 1'b1;
            w_s1_special_val = C_QNAN;
        end else if (w_inf_a) begin
            w_s1_special     = 1'b1;
            w_s1_special_val = {w_sa, C_EXP_MAX, 23'd0};
        end else if (w_inf_b) begin
            w_s1_special     = 1'b1;
            w_s1_special_val = {w_sb, C_EXP_MAX, 23'd0};
        end

        // Zeroed mantissas make the adder operands collapse to 0 downstream.
        if (w_s1_special) begin
            w_s1_eff_sub   = 1'b0;
            w_s1_sign      = 1'b0;
            w_s1_exp       = 8'd0;
            w_s1_diff      = 8'd0;
            w_s1_big_man   = 24'd0;
            w_s1_small_man = 24'd0;
        end
    end

    logic [23:0] r_s1_big_man;
    logic [23:0] r_s1_small_man;
    logic [7:0]  r_s1_diff;
    logic [7:0]  r_s1_exp;
    logic        r_s1_sign;
    logic        r_s1_eff_sub;
    logic        r_s1_special;
    logic [31:0] r_s1_special_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid       <= 1'b0;
            r_s1_big_man     <= 24'd0;
            r_s1_small_man   <= 24'd0;
            r_s1_diff        <= 8'd0;
            r_s1_exp         <= 8'd0;
            r_s1_sign        <= 1'b0;
            r_s1_eff_sub     <= 1'b0;
            r_s1_special     <= 1'b0;
            r_s1_special_val <= 32'd0;
        end else begin
            if (w_s1_ready) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_s1_load) begin
                r_s1_big_man     <= w_s1_big_man;
                r_s1_small_man   <= w_s1_small_man;
                r_s1_diff        <= w_s1_diff;
                r_s1_exp         <= w_s1_exp;
                r_s1_sign        <= w_s1_sign;
                r_s1_eff_sub     <= w_s1_eff_sub;
                r_s1_special     <= w_s1_special;
                r_s1_special_val <= w_s1_special_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: align smaller mantissa with sticky, complement for subtract
    // ------------------------------------------------------------------
    logic [31:0] w_m_big;
    logic [31:0] w_m_small;
    logic [31:0] w_shift_mask;
    logic [31:0] w_shifted;
    logic        w_sticky;
    logic [31:0] w_small_al;
    logic [31:0] w_add_b;

    assign w_m_big      = {2'b00, r_s1_big_man, 6'b0};
    assign w_m_small    = {2'b00, r_s1_small_man, 6'b0};
    assign w_shift_mask = ~(32'hFFFF_FFFF << r_s1_diff[4:0]);
    assign w_shifted    = w_m_small >> r_s1_diff[4:0];
    assign w_sticky     = |(w_m_small & w_shift_mask);

    always_comb begin
        w_small_al = {w_shifted[31:1], w_shifted[0] | w_sticky};
        if (r_s1_diff >= 8'd32) begin
            w_small_al = {31'd0, |w_m_small};
        end
    end

    assign w_add_b = r_s1_eff_sub ? ~w_small_al : w_small_al;

    logic [31:0] r_add_a;
    logic [31:0] r_add_b;
    logic        r_add_cin;
    logic        r_eff_sub;
    logic        r_sign;
    logic [7:0]  r_exp;
    logic        r_special;
    logic [31:0] r_special_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid    <= 1'b0;
            r_add_a       <= 32'd0;
            r_add_b       <= 32'd0;
            r_add_cin     <= 1'b0;
            r_eff_sub     <= 1'b0;
            r_sign        <= 1'b0;
            r_exp         <= 8'd0;
            r_special     <= 1'b0;
            r_special_val <= 32'd0;
        end else begin
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load) begin
                r_add_a       <= w_m_big;
                r_add_b       <= w_add_b;
                r_add_cin     <= r_s1_eff_sub;
                r_eff_sub     <= r_s1_eff_sub;
                r_sign        <= r_s1_sign;
                r_exp         <= r_s1_exp;
                r_special     <= r_s1_special;
                r_special_val <= r_s1_special_val;
            end
        end
    end

    assign bus.in_ready    = w_s1_ready;
    assign bus.out_valid   = r_s2_valid;
    assign bus.add_a       = r_add_a;
    assign bus.add_b       = r_add_b;
    assign bus.add_cin     = r_add_cin;
    assign bus.eff_sub     = r_eff_sub;
    assign bus.sign_out    = r_sign;
    assign bus.exp_out     = r_exp;
    assign bus.special     = r_special;
    assign bus.special_val = r_special_val;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_align.sv
// ============================================================================
//  Module      : tb_fp_add_align
//  Description : Scoreboard bench for fp_add_align with hand-computed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_add_align;

    typedef struct packed {
        logic [31:0] add_a;
        logic [31:0] add_b;
        logic        cin;
        logic        eff_sub;
        logic        sign;
        logic [7:0]  exp;
        logic        special;
        logic [31:0] sval;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        res_t        r;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_add_align_if bus ();

    fp_add_align u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    res_t q_exp[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic res_t got();
        return '{bus.add_a, bus.add_b, bus.add_cin, bus.eff_sub, bus.sign_out,
                 bus.exp_out, bus.special, bus.special_val};
    endfunction

    function automatic vec_t mk(input logic [31:0] a, b, input logic s,
                                input logic [31:0] ea, eb, input logic ec, esub, esign,
                                input logic [7:0] eexp, input logic esp, input logic [31:0] esv);
        vec_t v;
        v.a = a; v.b = b; v.s = s;
        v.r = '{ea, eb, ec, esub, esign, eexp, esp, esv};
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compare every transfer against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_vec++;
            if (q_exp.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got %h expected none", got());
            end else begin
                res_t e;
                e = q_exp.pop_front();
                if (got() !== e) begin
                    n_err++;
                    $display("FAIL result: got %h expected %h", got(), e);
                end
            end
        end
    end

    task automatic send(input vec_t v);
        int n;
        bus.in_valid = 1'b1;
        bus.op_a     = v.a;
        bus.op_b     = v.b;
        bus.sub      = v.s;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            q_exp.push_back(v.r);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_exp.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("drain_empty", 128'(q_exp.size()), 128'd0);
    endtask

    vec_t vecs[$];
    res_t snap;

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // a, b, sub | add_a, add_b, cin, eff_sub, sign, exp, special, special_val
        vecs.push_back(mk(32'h3F800000, 32'h3F800000, 0, 32'h20000000, 32'h20000000, 0, 0, 0, 8'h7F, 0, 32'h0));
        vecs.push_back(mk(32'h3F800000, 32'h3F000000, 1, 32'h20000000, 32'hEFFFFFFF, 1, 1, 0, 8'h7F, 0, 32'h0));
        vecs.push_back(mk(32'h3F000000, 32'h3F800000, 1, 32'h20000000, 32'hEFFFFFFF, 1, 1, 1, 8'h7F, 0, 32'h0));
        vecs.push_back(mk(32'h3F800000, 32'h2B800000, 0, 32'h20000000, 32'h00000001, 0, 0, 0, 8'h7F, 0, 32'h0));
        vecs.push_back(mk(32'h7F800000, 32'h7F800000, 1, 32'h0, 32'h0, 0, 0, 0, 8'h00, 1, 32'h7FC00000));
        vecs.push_back(mk(32'h7FC00001, 32'h3F800000, 0, 32'h0, 32'h0, 0, 0, 0, 8'h00, 1, 32'h7FC00000));
        vecs.push_back(mk(32'hFF800000, 32'h3F800000, 0, 32'h0, 32'h0, 0, 0, 0, 8'h00, 1, 32'hFF800000));
        vecs.push_back(mk(32'h3F800000, 32'h3F800000, 1, 32'h20000000, 32'hDFFFFFFF, 1, 1, 0, 8'h7F, 0, 32'h0));
        vecs.push_back(mk(32'h00000000, 32'h00000000, 0, 32'h0, 32'h0, 0, 0, 0, 8'h01, 0, 32'h0));
        vecs.push_back(mk(32'h00000001, 32'h00800000, 0, 32'h20000000, 32'h00000040, 0, 0, 0, 8'h01, 0, 32'h0));
        vecs.push_back(mk(32'h3F800000, 32'h3B800001, 0, 32'h20000000, 32'h00200001, 0, 0, 0, 8'h7F, 0, 32'h0));
        vecs.push_back(mk(32'h3F800000, 32'h2F800000, 0, 32'h20000000, 32'h00000001, 0, 0, 0, 8'h7F, 0, 32'h0));
        vecs.push_back(mk(32'h3F800000, 32'h34000000, 0, 32'h20000000, 32'h00000040, 0, 0, 0, 8'h7F, 0, 32'h0));
        vecs.push_back(mk(32'h7F800000, 32'hFF800000, 0, 32'h0, 32'h0, 0, 0, 0, 8'h00, 1, 32'h7FC00000));
        vecs.push_back(mk(32'h3F800000, 32'h7F800000, 1, 32'h0, 32'h0, 0, 0, 0, 8'h00, 1, 32'hFF800000));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_outputs", 128'(got()), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency on an idle pipe
        send(vecs[0]);
        check("latency_c1", 128'(bus.out_valid), 128'd0);
        @(posedge clk);
        #1;
        check("latency_c2", 128'(bus.out_valid), 128'd1);
        drain();

        // Directed vectors back-to-back
        for (int i = 1; i < vecs.size(); i++) send(vecs[i]);
        drain();

        // Stream of 4 with a 3-cycle downstream stall
        fork
            begin
                send(vecs[1]);
                send(vecs[2]);
                send(vecs[3]);
                send(vecs[10]);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                check("stall_valid", 128'(bus.out_valid), 128'd1);
                snap = got();
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk);
                    #1;
                    check("stall_in_ready", 128'(bus.in_ready), 128'd0);
                    check("stall_hold", 128'(got()), 128'(snap));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two items in flight
        send(vecs[1]);
        send(vecs[2]);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        q_exp.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(vecs[3]);
        check("postrst_c1", 128'(bus.out_valid), 128'd0);
        @(posedge clk);
        #1;
        check("postrst_c2", 128'(bus.out_valid), 128'd1);
        drain();
        repeat (4) @(posedge clk);
        #1;
        check("postrst_idle", 128'(bus.out_valid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
